// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);
  logic [WIDTH:0] sh, diff;
  assign sh = {rem_in, quot_in[WIDTH-1]};
  // rem < divisor keeps sh < 2*divisor, so diff[WIDTH] is a clean borrow flag
  assign diff = sh - {1'b0, divisor};
  assign rem_out = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_out = {quot_in[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer; DIV_ZERO_FAST_EN skips CALC/FIXUP when b==0.
module div_seq_ctrl
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int CW = $clog2(WIDTH);
`ifdef DIV_ZERO_FAST_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, q_q, q_d, r_q, r_d;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic negq_q, negq_d, negr_q, negr_d;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem_q), .quot_in(quot_q), .divisor(dvs_q),
    .rem_out(step_rem), .quot_out(step_quot)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quot_d = quot_q;
    dvs_d = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    q_d = q_q;
    r_d = r_q;
    case (state_q)
      IDLE: if (start && !cancel) begin
        state_d = (ZERO_FAST && b == '0) ? DONE : CALC;
        cnt_d = '0;
        rem_d = '0;
        quot_d = (sign && a[WIDTH-1]) ? -a : a;
        dvs_d = (sign && b[WIDTH-1]) ? -b : b;
        negq_d = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        negr_d = sign && a[WIDTH-1];
        q_d = (ZERO_FAST && b == '0) ? '0 : q_q;
        r_d = (ZERO_FAST && b == '0) ? '0 : r_q;
      end
      CALC: if (cancel) state_d = IDLE;
      else begin
        rem_d = step_rem;
        quot_d = step_quot;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH-1)) ? FIXUP : CALC;
      end
      FIXUP: if (cancel) state_d = IDLE;
      else begin
        state_d = DONE;
        // divide by zero leaves an all-ones quotient in the datapath; force both to zero
        q_d = (dvs_q == '0) ? '0 : negq_q ? -quot_q : quot_q;
        r_d = (dvs_q == '0) ? '0 : negr_q ? -rem_q : rem_q;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quot_q <= '0;
      dvs_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quot_q <= quot_d;
      dvs_q <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      q_q <= q_d;
      r_q <= r_d;
    end
  end
  assign busy = (state_q == CALC) || (state_q == FIXUP);
  assign done = (state_q == DONE);
  assign q = q_q;
  assign r = r_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vectors against a cycle-level arithmetic model of the divider.
module tb_div_seq_ctrl;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sign = 1'b0, cancel = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] q, r;
  int nvec = 0, nerr = 0, ndone = 0;
  int cyc = 0, lat = 34;
  bit armed = 1'b0;
  logic [31:0] mq = '0, mr = '0, pq = '0, pr = '0;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clock(clk), .reset(reset), .start(start), .sign(sign), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rq, output logic [31:0] rr);
    if (y == 0) begin rq = 0; rr = 0; end
    else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rq = 32'h8000_0000; rr = 0; end
    else if (s) begin rq = $signed(x) / $signed(y); rr = $signed(x) % $signed(y); end
    else begin rq = x / y; rr = x % y; end
  endtask

  // model: cyc counts cycles since the accepted start; busy before lat, done at lat
  initial forever begin
    @(posedge clk);
    if (reset) begin cyc = 0; mq = 0; mr = 0; armed = 1'b1; end
    else if (cyc == 0) begin
      if (start && !cancel) begin
        ref_div(sign, a, b, pq, pr);
        lat = (FAST && b == 0) ? 1 : 34;
        cyc = 1;
        if (lat == 1) begin mq = pq; mr = pr; end
      end
    end
    else if (cyc < lat && cancel) cyc = 0;
    else if (cyc == lat) cyc = 0;
    else begin
      cyc++;
      if (cyc == lat) begin mq = pq; mr = pr; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("busy", {31'b0, busy}, {31'b0, cyc >= 1 && cyc < lat});
      check("done", {31'b0, done}, {31'b0, cyc != 0 && cyc == lat});
      check("q", q, mq);
      check("r", r, mr);
      if (done) ndone++;
    end
  end

  task automatic kick(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sign = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eq, input logic [31:0] er, input int elat);
    int n;
    kick(s, x, y);
    n = 1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check({nm, "_lat"}, 32'(n), 32'(elat));
    check({nm, "_q"}, q, eq);
    check({nm, "_r"}, r, er);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    reset = 1'b0;
    run_op("divu_100_7", 1'b0, 100, 7, 14, 2, 34);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 34);
    run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 34);
    n0 = ndone;
    kick(1'b0, 50, 5);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'b0, busy}, 0);
    repeat (40) @(negedge clk);
    check("cancel_ndone", 32'(ndone - n0), 0);
    check("cancel_q", q, 0);
    check("cancel_r", r, 32'h8000_0000);
    run_op("divu_20_3", 1'b0, 20, 3, 6, 2, 34);
    run_op("div_b0", 1'b1, 123, 0, 0, 0, FAST ? 1 : 34);
    run_op("divu_b0", 1'b0, 123, 0, 0, 0, FAST ? 1 : 34);
    @(negedge clk);
    sign = 1'b0; a = 9; b = 2; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", {31'b0, busy}, 0);
    repeat (3) @(negedge clk);
    n0 = ndone;
    sign = 1'b0; a = 1000; b = 10; start = 1'b1;
    repeat (36) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("held_ndone", 32'(ndone - n0), 2);
    check("held_q", q, 100);
    check("held_r", r, 0);
    kick(1'b0, 77, 5);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
